// File: rtl/uart_loader_if.sv
// Bus-master port bundle for the serial loader.
// Handshake: the master raises master_req with wen/mode/num/addr/dat_o and
// holds them stable; the transfer completes on the rising clock edge where
// master_req && master_ready are both high (master_dat_i is sampled on that
// edge for reads). master_req is low on the following clock. master_ready
// seen while master_req is low carries no meaning and is ignored.
interface uart_loader_if #(
  parameter int XLEN        = 32,
  parameter int SLAVE_WIDTH = 4
);
  logic                        master_req;
  logic                        master_wen;
  logic [2:0]                  master_mode;
  logic [SLAVE_WIDTH-1:0]      master_num;
  logic [XLEN-SLAVE_WIDTH-1:0] master_addr;
  logic [XLEN-1:0]             master_dat_o;
  logic [XLEN-1:0]             master_dat_i;
  logic                        master_ready;

  modport master (
    output master_req, master_wen, master_mode, master_num, master_addr, master_dat_o,
    input  master_dat_i, master_ready
  );

  modport slave (
    input  master_req, master_wen, master_mode, master_num, master_addr, master_dat_o,
    output master_dat_i, master_ready
  );
endinterface

// File: rtl/uart_loader.sv
// Serial debug/boot loader: turns UART command frames into single word bus
// reads/writes, controls the CPU hold line and answers every frame on TX.
module uart_loader #(
  parameter int XLEN        = 32,
  parameter int SLAVE_WIDTH = 4,
  parameter int CLK_DIV     = 16,
  parameter int TIMEOUT     = 65536,
  parameter bit HOLD_RESET  = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx_line,
  output logic          tx_line,
  output logic          hold_cpu,
  output logic          busy,
  output logic [2:0]    frame_state,
  uart_loader_if.master bus
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] FULL = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2 - 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  localparam logic [7:0] CMD_WR   = 8'hA5;
  localparam logic [7:0] CMD_RD   = 8'hC3;
  localparam logic [7:0] CMD_REL  = 8'h0F;
  localparam logic [7:0] CMD_HOLD = 8'hF0;
  localparam logic [7:0] RSP_OK   = 8'h5A;
  localparam logic [7:0] RSP_ERR  = 8'hEE;

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  // CMD is the one-cycle launch state between a complete, valid bus frame and BUS.
  typedef enum logic [2:0] {F_IDLE, F_CMD, F_ADDR, F_DATA, F_BUS, F_RESP} f_state_t;

  // ---------------- RX path ----------------
  logic      rx_meta, rx_s, rx_d;
  rx_state_t rx_state, rx_nxt;
  logic [CW-1:0] rx_cnt;
  logic [2:0] rx_bit;
  logic [7:0] rx_byte;
  logic       rx_full, rx_half, rx_valid;

  // Two-flop synchronizer plus one delay flop for falling-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      rx_meta <= rx_line;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

  assign rx_full  = (rx_cnt == FULL);
  assign rx_half  = (rx_cnt == HALF);
  // A byte is accepted on the edge that samples a high stop bit.
  assign rx_valid = (rx_state == R_STOP) && rx_full && rx_s;

  // RX state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_state <= R_IDLE;
    else     rx_state <= rx_nxt;
  end

  // RX next state: mid-bit sampling, false-start and framing-error rejection.
  always_comb begin
    rx_nxt = rx_state;
    case (rx_state)
      R_IDLE:  if (rx_d && !rx_s) rx_nxt = R_START;
      R_START: if (rx_half) rx_nxt = rx_s ? R_IDLE : R_DATA;
      R_DATA:  if (rx_full && (rx_bit == 3'd7)) rx_nxt = R_STOP;
      R_STOP:  if (rx_full) rx_nxt = R_IDLE;
      default: rx_nxt = R_IDLE;
    endcase
  end

  // RX bit timer and LSB-first shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_cnt  <= '0;
      rx_bit  <= '0;
      rx_byte <= '0;
    end else begin
      if ((rx_state == R_IDLE) || ((rx_state == R_START) && rx_half) || rx_full)
        rx_cnt <= '0;
      else
        rx_cnt <= rx_cnt + 1'b1;
      if (rx_state == R_IDLE)
        rx_bit <= '0;
      else if ((rx_state == R_DATA) && rx_full) begin
        rx_bit  <= rx_bit + 1'b1;
        rx_byte <= {rx_s, rx_byte[7:1]};
      end
    end
  end

  // ---------------- TX path ----------------
  logic          tx_busy, tx_load, tx_end, tx_avail;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_bit;
  logic [9:0]    tx_shift;
  logic [XLEN-1:0] resp_buf;
  logic [2:0]      resp_left;

  assign tx_end   = tx_busy && (tx_cnt == FULL) && (tx_bit == 4'd9);
  // A new byte may load on the last clock of the previous stop bit, so
  // consecutive response bytes leave no idle gap.
  assign tx_avail = !tx_busy || tx_end;
  assign tx_line  = tx_busy ? tx_shift[0] : 1'b1;

  // TX shifter: start, 8 data bits LSB first, stop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_busy  <= 1'b0;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '1;
    end else if (tx_load) begin
      tx_busy  <= 1'b1;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= {1'b1, resp_buf[7:0], 1'b0};
    end else if (tx_busy) begin
      if (tx_cnt == FULL) begin
        tx_cnt <= '0;
        if (tx_bit == 4'd9) begin
          tx_busy <= 1'b0;
        end else begin
          tx_bit   <= tx_bit + 1'b1;
          tx_shift <= {1'b1, tx_shift[9:1]};
        end
      end else begin
        tx_cnt <= tx_cnt + 1'b1;
      end
    end
  end

  // ---------------- Frame FSM ----------------
  f_state_t f_state, f_nxt;
  logic [7:0]      cmd_q;
  logic [XLEN-1:0] addr_q, data_q;
  logic [1:0]      byte_idx;
  logic            mis_q;
  logic [TW-1:0]   to_cnt;
  logic            to_hit, req;
  logic            cmd_cap, addr_cap, data_cap, resp_set, hold_set, hold_clr;
  logic [XLEN-1:0] resp_val;
  logic [2:0]      resp_n;

  assign to_hit      = (to_cnt == TO_LAST);
  assign req         = (f_state == F_BUS);
  assign frame_state = f_state;
  assign busy        = (f_state != F_IDLE) &&
                       !((f_state == F_RESP) && (resp_left == 3'd0) && !tx_busy);

  // Frame state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) f_state <= F_IDLE;
    else     f_state <= f_nxt;
  end

  // Frame next state and datapath strobes.
  always_comb begin
    f_nxt    = f_state;
    cmd_cap  = 1'b0;
    addr_cap = 1'b0;
    data_cap = 1'b0;
    resp_set = 1'b0;
    resp_val = '0;
    resp_n   = 3'd0;
    hold_set = 1'b0;
    hold_clr = 1'b0;
    tx_load  = 1'b0;
    case (f_state)
      F_IDLE: begin
        if (rx_valid) begin
          cmd_cap = 1'b1;
          case (rx_byte)
            CMD_WR, CMD_RD: f_nxt = F_ADDR;
            CMD_REL: begin
              hold_clr = 1'b1;
              resp_set = 1'b1; resp_val = XLEN'(RSP_OK); resp_n = 3'd1; f_nxt = F_RESP;
            end
            CMD_HOLD: begin
              hold_set = 1'b1;
              resp_set = 1'b1; resp_val = XLEN'(RSP_OK); resp_n = 3'd1; f_nxt = F_RESP;
            end
            default: begin
              resp_set = 1'b1; resp_val = XLEN'(RSP_ERR); resp_n = 3'd1; f_nxt = F_RESP;
            end
          endcase
        end
      end
      F_ADDR: begin
        if (rx_valid) begin
          addr_cap = 1'b1;
          if (byte_idx == 2'd3) begin
            if (mis_q) begin
              resp_set = 1'b1; resp_val = XLEN'(RSP_ERR); resp_n = 3'd1; f_nxt = F_RESP;
            end else if (cmd_q == CMD_RD) begin
              f_nxt = F_CMD;
            end else begin
              f_nxt = F_DATA;
            end
          end
        end else if (to_hit) begin
          resp_set = 1'b1; resp_val = XLEN'(RSP_ERR); resp_n = 3'd1; f_nxt = F_RESP;
        end
      end
      F_DATA: begin
        if (rx_valid) begin
          data_cap = 1'b1;
          if (byte_idx == 2'd3) begin
            if (mis_q) begin
              resp_set = 1'b1; resp_val = XLEN'(RSP_ERR); resp_n = 3'd1; f_nxt = F_RESP;
            end else begin
              f_nxt = F_CMD;
            end
          end
        end else if (to_hit) begin
          resp_set = 1'b1; resp_val = XLEN'(RSP_ERR); resp_n = 3'd1; f_nxt = F_RESP;
        end
      end
      F_CMD: f_nxt = F_BUS;
      F_BUS: begin
        if (bus.master_ready) begin
          resp_set = 1'b1;
          f_nxt    = F_RESP;
          if (cmd_q == CMD_RD) begin
            resp_val = bus.master_dat_i; resp_n = 3'd4;
          end else begin
            resp_val = XLEN'(RSP_OK); resp_n = 3'd1;
          end
        end
      end
      F_RESP: begin
        if (resp_left != 3'd0) begin
          if (tx_avail) tx_load = 1'b1;
        end else if (!tx_busy) begin
          f_nxt = F_IDLE;
        end
      end
      default: f_nxt = F_IDLE;
    endcase
  end

  // Frame datapath: command/address/data capture, response buffer, hold line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      byte_idx  <= '0;
      mis_q     <= 1'b0;
      resp_buf  <= '0;
      resp_left <= '0;
      hold_cpu  <= HOLD_RESET;
    end else begin
      if (cmd_cap) cmd_q <= rx_byte;
      if (addr_cap) begin
        addr_q <= {rx_byte, addr_q[XLEN-1:8]};
        if (byte_idx == 2'd0) mis_q <= (rx_byte[1:0] != 2'b00);
      end
      if (data_cap) data_q <= {rx_byte, data_q[XLEN-1:8]};
      if (f_state == F_IDLE)
        byte_idx <= '0;
      else if (addr_cap || data_cap)
        byte_idx <= byte_idx + 1'b1;
      if (resp_set) begin
        resp_buf  <= resp_val;
        resp_left <= resp_n;
      end else if (tx_load) begin
        resp_buf  <= {8'h00, resp_buf[XLEN-1:8]};
        resp_left <= resp_left - 1'b1;
      end
      if (hold_set)      hold_cpu <= 1'b1;
      else if (hold_clr) hold_cpu <= 1'b0;
    end
  end

  // Inter-byte silence counter, only running inside ADDR/DATA.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      to_cnt <= '0;
    else if (rx_valid || !((f_state == F_ADDR) || (f_state == F_DATA)))
      to_cnt <= '0;
    else
      to_cnt <= to_cnt + 1'b1;
  end

  // Bus outputs are forced to zero whenever no request is outstanding.
  always_comb begin
    bus.master_req   = req;
    bus.master_wen   = req && (cmd_q == CMD_WR);
    bus.master_mode  = req ? 3'b010 : 3'b000;
    bus.master_num   = req ? addr_q[XLEN-1 -: SLAVE_WIDTH] : '0;
    bus.master_addr  = req ? addr_q[XLEN-SLAVE_WIDTH-1:0] : '0;
    bus.master_dat_o = (req && (cmd_q == CMD_WR)) ? data_q : '0;
  end

endmodule

// File: tb/tb_uart_loader.sv
// Bench for uart_loader: UART driver, bus slave model, TX monitor with an
// expected-byte queue and a bus expectation queue.
module tb_uart_loader;
  localparam int CLK_DIV = 16;
  localparam int TIMEOUT = 4096;
  localparam int PERIOD  = 10;
  localparam int BYTE_T  = 10 * CLK_DIV * PERIOD;

  typedef struct {
    logic        wen;
    logic [3:0]  num;
    logic [27:0] addr;
    logic [31:0] wdat;
    logic [31:0] rdat;
    bit          no_ack;
  } bus_exp_t;

  logic       clk, rst, rx_line;
  logic       tx_line, hold_cpu, busy;
  logic [2:0] frame_state;

  logic [7:0] exp_q[$];
  bus_exp_t   exp_bus_q[$];
  time        start_t[$];
  time        busy_fall_t;
  logic       busy_prev;
  int         vectors = 0;
  int         miscompares = 0;
  int         req_count = 0;

  logic [7:0] wr1 [9] = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
  logic [7:0] rd1 [5] = '{8'hC3, 8'h00, 8'h01, 8'h00, 8'h00};
  logic [7:0] rdm [5] = '{8'hC3, 8'h02, 8'h00, 8'h00, 8'h00};
  logic [7:0] tof [3] = '{8'hA5, 8'h00, 8'h01};
  logic [7:0] wr2 [9] = '{8'hA5, 8'h04, 8'h00, 8'h00, 8'h20, 8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] wr3 [9] = '{8'hA5, 8'h00, 8'h03, 8'h00, 8'h00, 8'h0D, 8'hF0, 8'hFE, 8'hCA};

  uart_loader_if #(.XLEN(32), .SLAVE_WIDTH(4)) bus ();

  uart_loader #(
    .XLEN(32), .SLAVE_WIDTH(4), .CLK_DIV(CLK_DIV), .TIMEOUT(TIMEOUT), .HOLD_RESET(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .rx_line(rx_line), .tx_line(tx_line),
    .hold_cpu(hold_cpu), .busy(busy), .frame_state(frame_state), .bus(bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #(PERIOD/2) clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    rx_line = 1'b0;
    repeat (CLK_DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_line = b[i];
      repeat (CLK_DIV) @(negedge clk);
    end
    rx_line = stop;
    repeat (CLK_DIV) @(negedge clk);
    rx_line = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic push_bus(input logic wen, input logic [3:0] num, input logic [27:0] addr,
                          input logic [31:0] wdat, input logic [31:0] rdat, input bit no_ack);
    bus_exp_t e;
    e.wen = wen; e.num = num; e.addr = addr; e.wdat = wdat; e.rdat = rdat; e.no_ack = no_ack;
    exp_bus_q.push_back(e);
  endtask

  task automatic wait_done(input int limit);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || exp_bus_q.size() != 0 || busy) && k < limit) begin
      @(negedge clk);
      k++;
    end
    vectors++;
    if (k >= limit) begin
      miscompares++;
      $display("FAIL done_timeout: %0d tx bytes and %0d bus cycles still pending after %0d clocks",
               exp_q.size(), exp_bus_q.size(), limit);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_req_low();
    int k;
    k = 0;
    while (bus.master_req === 1'b1 && k < 5000) begin
      @(negedge clk);
      k++;
    end
  endtask

  // Scoreboard monitor: decode TX bytes and compare against the expected queue
  initial begin
    logic [7:0] b;
    logic       stop;
    forever begin
      @(negedge clk);
      if (tx_line === 1'b0) begin
        start_t.push_back($time);
        repeat (CLK_DIV/2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CLK_DIV) @(negedge clk);
          b[i] = tx_line;
        end
        repeat (CLK_DIV) @(negedge clk);
        stop = tx_line;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_tx: got %02h, expected no byte", b);
        end else begin
          check("tx_byte", {24'h0, b}, {24'h0, exp_q.pop_front()});
        end
        check("tx_stop", {31'h0, stop}, 32'h1);
      end
    end
  end

  // Busy falling-edge timestamp
  initial begin
    busy_prev   = 1'b0;
    busy_fall_t = 0;
    forever begin
      @(negedge clk);
      if (busy_prev === 1'b1 && busy === 1'b0) busy_fall_t = $time;
      busy_prev = busy;
    end
  end

  // Bus slave model: compares request fields, answers ready three clocks later
  initial begin
    bus_exp_t e;
    bus.master_ready = 1'b0;
    bus.master_dat_i = '0;
    forever begin
      @(negedge clk);
      if (bus.master_req === 1'b1) begin
        req_count++;
        if (exp_bus_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_req: got req with num %0h addr %07h, expected no request",
                   bus.master_num, bus.master_addr);
          wait_req_low();
        end else begin
          e = exp_bus_q.pop_front();
          check("bus_wen", {31'h0, bus.master_wen}, {31'h0, e.wen});
          check("bus_mode", {29'h0, bus.master_mode}, 32'h2);
          check("bus_num", {28'h0, bus.master_num}, {28'h0, e.num});
          check("bus_addr", {4'h0, bus.master_addr}, {4'h0, e.addr});
          if (e.wen) check("bus_dat_o", bus.master_dat_o, e.wdat);
          if (e.no_ack) begin
            wait_req_low();
          end else begin
            repeat (3) @(negedge clk);
            bus.master_ready = 1'b1;
            bus.master_dat_i = e.rdat;
            @(negedge clk);
            bus.master_ready = 1'b0;
            bus.master_dat_i = '0;
            check("req_drop", {31'h0, bus.master_req}, 32'h0);
          end
        end
      end
    end
  end

  // Directed stimulus
  initial begin
    int rc;
    int k;
    rst     = 1'b1;
    rx_line = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_hold", {31'h0, hold_cpu}, 32'h1);
    check("rst_tx", {31'h0, tx_line}, 32'h1);
    check("rst_req", {31'h0, bus.master_req}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_mode", {29'h0, bus.master_mode}, 32'h0);
    check("rst_state", {29'h0, frame_state}, 32'h0);

    // RELEASE then HOLD
    exp_q.push_back(8'h5A);
    send_byte(8'h0F, 1'b1);
    wait_done(2000);
    check("hold_after_release", {31'h0, hold_cpu}, 32'h0);
    exp_q.push_back(8'h5A);
    send_byte(8'hF0, 1'b1);
    wait_done(2000);
    check("hold_after_hold", {31'h0, hold_cpu}, 32'h1);

    // Word write while the CPU is held
    push_bus(1'b1, 4'h0, 28'h0000100, 32'hDEADBEEF, 32'h0, 1'b0);
    exp_q.push_back(8'h5A);
    foreach (wr1[i]) send_byte(wr1[i], 1'b1);
    wait_done(2000);

    // Word read: four bytes back-to-back, busy drops one byte time after the last start
    push_bus(1'b0, 4'h0, 28'h0000100, 32'h0, 32'h12345678, 1'b0);
    exp_q.push_back(8'h78); exp_q.push_back(8'h56);
    exp_q.push_back(8'h34); exp_q.push_back(8'h12);
    start_t.delete();
    foreach (rd1[i]) send_byte(rd1[i], 1'b1);
    wait_done(3000);
    check("rd_starts", start_t.size(), 4);
    if (start_t.size() == 4) begin
      for (int i = 0; i < 3; i++)
        check("rd_gap", 32'(start_t[i+1] - start_t[i]), 32'(BYTE_T));
      check("rd_busy_fall", 32'(busy_fall_t - start_t[3]), 32'(BYTE_T));
    end

    // Misaligned read and unknown command
    rc = req_count;
    exp_q.push_back(8'hEE);
    foreach (rdm[i]) send_byte(rdm[i], 1'b1);
    wait_done(2000);
    check("misaligned_no_req", rc, req_count);
    exp_q.push_back(8'hEE);
    send_byte(8'h77, 1'b1);
    wait_done(2000);

    // Inter-byte timeout, then a normal write
    exp_q.push_back(8'hEE);
    foreach (tof[i]) send_byte(tof[i], 1'b1);
    wait_done(TIMEOUT + 3000);
    push_bus(1'b1, 4'h2, 28'h0000004, 32'h44332211, 32'h0, 1'b0);
    exp_q.push_back(8'h5A);
    foreach (wr2[i]) send_byte(wr2[i], 1'b1);
    wait_done(2000);

    // Reset while a request is outstanding
    exp_q.push_back(8'h5A);
    send_byte(8'h0F, 1'b1);
    wait_done(2000);
    push_bus(1'b1, 4'h0, 28'h0000300, 32'hCAFEF00D, 32'h0, 1'b1);
    foreach (wr3[i]) send_byte(wr3[i], 1'b1);
    k = 0;
    while (bus.master_req !== 1'b1 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check("req_before_rst", {31'h0, bus.master_req}, 32'h1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_req", {31'h0, bus.master_req}, 32'h0);
    check("rst_mid_tx", {31'h0, tx_line}, 32'h1);
    check("rst_mid_busy", {31'h0, busy}, 32'h0);
    check("rst_mid_hold", {31'h0, hold_cpu}, 32'h1);
    check("rst_mid_state", {29'h0, frame_state}, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Framing error: discarded, FSM stays idle; the next byte is a fresh command
    send_byte(8'hA5, 1'b0);
    repeat (4) @(negedge clk);
    check("frame_err_state", {29'h0, frame_state}, 32'h0);
    check("frame_err_busy", {31'h0, busy}, 32'h0);
    exp_q.push_back(8'h5A);
    send_byte(8'h0F, 1'b1);
    wait_done(2000);
    check("hold_final", {31'h0, hold_cpu}, 32'h0);

    check("req_total", req_count, 4);
    check("tx_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
